// File: rtl/rrarb_pkg.sv
// Shared types and helpers for the round-robin arbitrated multiplexer.
package rrarb_pkg;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} rrarb_state_t;

  // Channel-index width; a single channel still carries a 1-bit index.
  function automatic int clog2min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rrarb_pick.sv
// Rotating-priority picker: the first requester at or after ptr wins,
// wrapping modulo NCH.
module rrarb_pick #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx,
  output logic           any
);

  logic [NCH-1:0] rot;
  int             pos;

  always_comb begin
    // Bit j of rot is the request of channel (ptr + j) mod NCH.
    rot = NCH'({req, req} >> ptr);
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any = 1'b1;
        pos = int'(ptr) + j;
      end
    end
    if (pos >= NCH) pos = pos - NCH;
    if (any) begin
      gnt[pos] = 1'b1;
      idx      = CW'(pos);
    end
  end

endmodule

// File: rtl/rrarb_mux.sv
// N-channel round-robin arbitrated mux with valid/ready inputs, optional
// packet locking, and a single registered output stage.
module rrarb_mux
  import rrarb_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  WIDTH = 64,
  parameter int  LOCK  = 1,
  localparam int CW    = clog2min1(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_last,
  input  logic                 out_ready
);

  rrarb_state_t     state;
  logic [CW-1:0]    rr_ptr;
  logic [CW-1:0]    lock_ch;

  logic [NCH-1:0]   arb_gnt;
  logic [CW-1:0]    arb_idx;
  logic             arb_any;

  logic [NCH-1:0]   grant;
  logic [CW-1:0]    gidx;
  logic             gany;
  logic [CW-1:0]    ptr_nxt;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [CW-1:0]    ch_p1;
  logic             last_p1;

  rrarb_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_pick (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // While locked only the owning channel may transfer; an idle owner
  // produces a bubble rather than handing the port to someone else.
  always_comb begin
    grant = arb_gnt;
    gidx  = arb_idx;
    gany  = arb_any;
    if (state == LOCKED) begin
      grant          = '0;
      grant[lock_ch] = in_valid[lock_ch];
      gidx           = lock_ch;
      gany           = in_valid[lock_ch];
    end
  end

  assign load_en  = !vld_p1 || out_ready;
  assign in_ready = (reset_n && load_en) ? grant : '0;
  assign xfer     = gany && load_en && reset_n;
  assign sel_data = in_data[gidx*WIDTH +: WIDTH];
  assign sel_last = in_last[gidx];
  assign ptr_nxt  = (int'(gidx) == NCH - 1) ? '0 : gidx + CW'(1);

  // Stage p1: output register, arbitration pointer and lock tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ARB;
      rr_ptr  <= '0;
      lock_ch <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      last_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      ch_p1   <= gidx;
      last_p1 <= sel_last;
      if (sel_last || (LOCK == 0)) begin
        rr_ptr <= ptr_nxt;
        state  <= ARB;
      end else begin
        state   <= LOCKED;
        lock_ch <= gidx;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_last  = last_p1;

endmodule
